ppm_encoder_2bits: RTL and testbench
====================================

PPM_ENCODER_2BITS -- requirements
Module: ppm_encoder_2bits

Interface
REQ-001 SHALL provide port: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port: clk16  input  1  slot-enable strobe, one clk cycle wide; one PPM slot per strobe.
REQ-004 SHALL provide port: tx_data  input  8  byte to transmit.
REQ-005 SHALL provide port: tx_valid  input  1  tx_data/tx_last valid.
REQ-006 SHALL provide port: tx_last  input  1  byte is final byte of frame.
REQ-007 SHALL provide port: tx_ready  output  1  one-entry holding register empty; byte accepted on clk edge with tx_valid && tx_ready.
REQ-008 SHALL provide port: dout  output  1  PPM line, active-low pulse, idle high, driven from a flop.
REQ-009 SHALL provide port: busy  output  1  high in any state other than IDLE.
REQ-010 SHALL provide port: frame_done  output  1  one-clk pulse on the clk16 edge that leaves EOF.
REQ-011 SHALL provide port: underrun  output  1  one-clk pulse on the clk16 edge that starts a filler period.

Function
REQ-012 SHALL use a 3-bit slot counter (0..7) advancing only on clk edges with clk16=1 while busy; 8 slots = one symbol period; wraps 7->0 at period boundaries.
REQ-013 SHALL update state, slot counter and dout together on clk16-enabled edges; dout holds the value for the slot being entered; no change to dout when clk16=0.
REQ-014 SHALL implement states IDLE, SOF, DATA, FILL, EOF.
REQ-015 IDLE: dout=1, slot=0; on a clk16 edge with holding register full -> SOF, slot 0.
REQ-016 SOF: one period; dout=0 in slots 0-1, 1 in slots 2-7; at period end load holding byte into shift register, free holding register -> DATA.
REQ-017 DATA: 4 symbol periods per byte, dibits MSB first ([7:6],[5:4],[3:2],[1:0]); dout=0 only in slot 2*dibit+1 (00->1, 01->3, 10->5, 11->7).
REQ-018 At the end of the 4th dibit period: byte was last -> EOF; else holding full -> load next byte, stay DATA with no gap; else -> FILL with underrun pulse.
REQ-019 FILL: whole periods of dout=1; at each period end, holding full -> load, DATA; else another FILL period with another underrun pulse.
REQ-020 EOF: one period; dout=0 in slots 0-3, 1 in slots 4-7; at period end -> IDLE with frame_done pulse.
REQ-021 tx_ready SHALL be !holding_full; acceptance and load on the same edge SHALL leave the register full with the new byte (load frees first).
REQ-022 tx_last SHALL be stored with its byte; bytes offered after a last byte wait in the holding register and start a new frame via IDLE.
REQ-023 clk16 asserted every clk cycle SHALL be legal (one slot per clk).

Reset
REQ-024 On rst_n=0: state IDLE, slot 0, holding register empty, shift register 0, dout=1, tx_ready=1, busy=0, frame_done=0, underrun=0; in-flight frame discarded without EOF.
REQ-025 After release, no transition before the first clk16 edge; handshake acceptance allowed immediately.

Verification
REQ-026 Byte 0x1B, tx_last=1 -> SOF low slots 0,1; dibit periods low at slots 1,3,5,7; EOF low 0-3; frame_done after 48 clk16 strobes; busy high throughout.
REQ-027 0xE4 then 0x00(last) back-to-back -> dibit pulses at slots 7,5,3,1,1,1,1,1 in consecutive periods, no FILL, no underrun.
REQ-028 0x55 (not last), tx_valid low for 20 strobes, then 0xAA(last) -> 4 periods pulses at slot 3, FILL periods each with one underrun pulse, resume pulses 5,5,5,5, then EOF.
REQ-029 rst_n low during DATA slot 4 -> dout=1, tx_ready=1, busy=0 asynchronously; next byte starts with full SOF.
REQ-030 clk16 held 0, two bytes offered -> first accepted, tx_ready=0, second held off, dout stays 1, busy=0.

Source files
------------

// File: rtl/ppm_encoder_2bits.sv
// 2-bit PPM line encoder. Each byte is sent as four symbol periods of eight
// slots. A period carries one dibit, sent MSB first. The line idles high.
// Each dibit is marked by a single low slot at position 2*dibit+1.
// A frame opens with a start-of-frame period, which is low in slots 0-1.
// It closes with an end-of-frame period, which is low in slots 0-3.
// If the next byte is late, the line sends all-high filler periods until it arrives.
module ppm_encoder_2bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk16,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dout,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_DATA,
        S_FILL,
        S_EOF
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_slot;
    logic [2:0] w_slot_next;
    logic       r_dout;
    logic       w_dout_next;
    logic [1:0] r_dibit_cnt;
    logic [1:0] w_dibit_cnt_next;
    logic [7:0] r_shift;
    logic [7:0] w_shift_next;
    logic       r_shift_last;
    logic       w_shift_last_next;
    logic [7:0] r_hold_data;
    logic       r_hold_last;
    logic       r_hold_full;
    logic       w_load;
    logic       r_frame_done;
    logic       w_frame_done_next;
    logic       r_underrun;
    logic       w_underrun_next;

    // Next-state, slot and line level. Nothing moves unless a slot strobe is present.
    always_comb begin
        w_state_next      = r_state;
        w_slot_next       = r_slot;
        w_dout_next       = r_dout;
        w_dibit_cnt_next  = r_dibit_cnt;
        w_shift_next      = r_shift;
        w_shift_last_next = r_shift_last;
        w_load            = 1'b0;
        w_frame_done_next = 1'b0;
        w_underrun_next   = 1'b0;
        if (clk16) begin
            if (r_state == S_IDLE) begin
                w_slot_next = 3'd0;
                if (r_hold_full) begin
                    w_state_next = S_SOF;
                end
            end else if (r_slot != 3'd7) begin
                w_slot_next = r_slot + 3'd1;
            end else begin
                // Period boundary: choose what the next period carries.
                w_slot_next = 3'd0;
                case (r_state)
                    S_SOF: begin
                        w_load           = 1'b1;
                        w_state_next     = S_DATA;
                        w_dibit_cnt_next = 2'd0;
                    end
                    S_DATA: begin
                        if (r_dibit_cnt != 2'd3) begin
                            w_dibit_cnt_next = r_dibit_cnt + 2'd1;
                            w_shift_next     = {r_shift[5:0], 2'b00};
                        end else if (r_shift_last) begin
                            w_state_next = S_EOF;
                        end else if (r_hold_full) begin
                            w_load           = 1'b1;
                            w_dibit_cnt_next = 2'd0;
                        end else begin
                            w_state_next    = S_FILL;
                            w_underrun_next = 1'b1;
                        end
                    end
                    S_FILL: begin
                        if (r_hold_full) begin
                            w_load           = 1'b1;
                            w_state_next     = S_DATA;
                            w_dibit_cnt_next = 2'd0;
                        end else begin
                            w_underrun_next = 1'b1;
                        end
                    end
                    S_EOF: begin
                        w_state_next      = S_IDLE;
                        w_frame_done_next = 1'b1;
                    end
                    default: begin
                        w_state_next = S_IDLE;
                    end
                endcase
            end
            if (w_load) begin
                w_shift_next      = r_hold_data;
                w_shift_last_next = r_hold_last;
            end
            // The line level follows the slot being entered. In DATA, the current dibit is always shift[7:6].
            case (w_state_next)
                S_SOF:   w_dout_next = |w_slot_next[2:1];
                S_DATA:  w_dout_next = (w_slot_next != {w_shift_next[7:6], 1'b1});
                S_EOF:   w_dout_next = w_slot_next[2];
                default: w_dout_next = 1'b1;
            endcase
        end
    end

    // Encoder state registers and registered line/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_slot       <= 3'd0;
            r_dout       <= 1'b1;
            r_dibit_cnt  <= 2'd0;
            r_shift      <= 8'd0;
            r_shift_last <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_slot       <= w_slot_next;
            r_dout       <= w_dout_next;
            r_dibit_cnt  <= w_dibit_cnt_next;
            r_shift      <= w_shift_next;
            r_shift_last <= w_shift_last_next;
            r_frame_done <= w_frame_done_next;
            r_underrun   <= w_underrun_next;
        end
    end

    // One-entry holding register. A load frees the entry before an acceptance on the same edge refills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_data <= 8'd0;
            r_hold_last <= 1'b0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (tx_valid && !r_hold_full) begin
                r_hold_data <= tx_data;
                r_hold_last <= tx_last;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign tx_ready   = !r_hold_full;
    assign dout       = r_dout;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_ppm_encoder_2bits.sv
// Randomized bench for ppm_encoder_2bits.
// The reference model treats the line as a queue of per-slot levels, one period at a time.
// At each period boundary, it decides the next period from a queue of waiting bytes and a queue of remaining dibits.
module tb_ppm_encoder_2bits;

    logic       clk;
    logic       rst_n;
    logic       clk16;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       dout;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    ppm_encoder_2bits dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk16      (clk16),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    // Period kinds: 0 = start of frame, 1 = data, 2 = filler, 3 = end of frame.
    bit         m_busy;
    int         m_kind;
    bit         m_slots[$];
    logic [1:0] m_dibits[$];
    bit         m_cur_last;
    logic [8:0] m_hold[$];
    bit         m_dout;
    bit         m_fd;
    bit         m_ur;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] period_bits(input int kind, input int d);
        logic [7:0] p;
        for (int s = 0; s < 8; s++) begin
            case (kind)
                0:       p[s] = (s >= 2);
                1:       p[s] = (s != 2 * d + 1);
                3:       p[s] = (s >= 4);
                default: p[s] = 1'b1;
            endcase
        end
        return p;
    endfunction

    task automatic start_period(input int kind, input int d);
        logic [7:0] p;
        p = period_bits(kind, d);
        m_kind = kind;
        m_slots.delete();
        for (int s = 0; s < 8; s++) m_slots.push_back(p[s]);
        m_dout = m_slots.pop_front();
    endtask

    task automatic load_byte();
        logic [8:0] h;
        h = m_hold.pop_front();
        m_cur_last = h[8];
        m_dibits.delete();
        m_dibits.push_back(h[7:6]);
        m_dibits.push_back(h[5:4]);
        m_dibits.push_back(h[3:2]);
        m_dibits.push_back(h[1:0]);
        start_period(1, int'(m_dibits.pop_front()));
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_kind = 0;
        m_slots.delete();
        m_dibits.delete();
        m_hold.delete();
        m_cur_last = 1'b0;
        m_dout = 1'b1;
        m_fd = 1'b0;
        m_ur = 1'b0;
    endtask

    // Advance the model across one rising edge, using the inputs now on the pins.
    task automatic model_step();
        bit hold_was_empty;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_fd = 1'b0;
        m_ur = 1'b0;
        hold_was_empty = (m_hold.size() == 0);
        if (clk16) begin
            if (!m_busy) begin
                if (!hold_was_empty) begin
                    m_busy = 1'b1;
                    start_period(0, 0);
                end else begin
                    m_dout = 1'b1;
                end
            end else if (m_slots.size() > 0) begin
                m_dout = m_slots.pop_front();
            end else begin
                case (m_kind)
                    0: load_byte();
                    1: begin
                        if (m_dibits.size() > 0) start_period(1, int'(m_dibits.pop_front()));
                        else if (m_cur_last) start_period(3, 0);
                        else if (!hold_was_empty) load_byte();
                        else begin
                            start_period(2, 0);
                            m_ur = 1'b1;
                        end
                    end
                    2: begin
                        if (!hold_was_empty) load_byte();
                        else begin
                            start_period(2, 0);
                            m_ur = 1'b1;
                        end
                    end
                    default: begin
                        m_busy = 1'b0;
                        m_fd = 1'b1;
                        m_dout = 1'b1;
                        m_slots.delete();
                    end
                endcase
            end
        end
        if (tx_valid && hold_was_empty) m_hold.push_back({tx_last, tx_data});
    endtask

    task automatic compare_all();
        check_val("dout", 32'(dout), 32'(m_dout));
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("tx_ready", 32'(tx_ready), 32'(m_hold.size() == 0));
        check_val("frame_done", 32'(frame_done), 32'(m_fd));
        check_val("underrun", 32'(underrun), 32'(m_ur));
    endtask

    // Scenario table: clk16 %, tx_valid %, tx_last %, random resets, cycles.
    int sc_c16[7]  = '{100, 100, 25, 100, 40, 0, 100};
    int sc_val[7]  = '{30, 2, 10, 50, 5, 100, 100};
    int sc_last[7] = '{30, 20, 40, 10, 50, 50, 100};
    int sc_rst[7]  = '{0, 0, 0, 1, 1, 0, 0};
    int sc_len[7]  = '{3000, 3000, 4000, 4000, 3000, 100, 500};

    initial begin
        int rst_cnt;
        rst_n    = 1'b0;
        clk16    = 1'b0;
        tx_data  = 8'd0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        rst_cnt  = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compare_all();
            tx_valid = 1'b1;
            model_step();
        end
        tx_valid = 1'b0;
        rst_n = 1'b1;
        for (int sc = 0; sc < 7; sc++) begin
            for (int cyc = 0; cyc < sc_len[sc]; cyc++) begin
                @(negedge clk);
                compare_all();
                if (rst_cnt > 0) begin
                    rst_cnt--;
                end else if (sc_rst[sc] != 0 && $urandom_range(0, 299) == 0) begin
                    rst_n = 1'b0;
                    rst_cnt = $urandom_range(0, 2);
                    #1;
                    check_val("async_dout", 32'(dout), 32'd1);
                    check_val("async_busy", 32'(busy), 32'd0);
                    check_val("async_ready", 32'(tx_ready), 32'd1);
                end else begin
                    rst_n = 1'b1;
                end
                clk16    = ($urandom_range(0, 99) < sc_c16[sc]);
                tx_valid = ($urandom_range(0, 99) < sc_val[sc]);
                tx_last  = ($urandom_range(0, 99) < sc_last[sc]);
                tx_data  = 8'($urandom);
                model_step();
            end
        end
        @(negedge clk);
        compare_all();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
